// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, reset vector and word-alignment helper
package cpu_pkg;
    typedef enum logic [1:0] {REQ, VALID, DRAIN} fetch_state_e;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: one-entry holding register for the instruction presented to ID
module if_fetch_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [DATA_W-1:0] d_pc,
    input  logic              d_bds,
    input  logic              d_cancel,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_add4,
    output logic              is_bds,
    output logic              cancel
);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N || clr) begin
            instr   <= '0;
            pc      <= '0;
            pc_add4 <= '0;
            is_bds  <= 1'b0;
            cancel  <= 1'b0;
        end else if (load) begin
            instr   <= d_instr;
            pc      <= d_pc;
            pc_add4 <= d_pc + DATA_W'(4);
            is_bds  <= d_bds;
            cancel  <= d_cancel;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and single-outstanding fetch handshake feeding IF/ID
module if_fetch_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter int          DATA_W       = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              IMEM_Req,
    output logic [DATA_W-1:0] IMEM_Addr,
    input  logic              IMEM_Ack,
    input  logic [DATA_W-1:0] IMEM_RData,
    input  logic              ID_Stall,
    input  logic              ID_IsBranch,
    input  logic              ID_BranchTaken,
    input  logic [DATA_W-1:0] ID_BranchTarget,
    input  logic              ID_CancelBDS,
    input  logic              EXC_Redirect,
    input  logic [DATA_W-1:0] EXC_Vector,
    output logic [DATA_W-1:0] IF_Instruction,
    output logic [DATA_W-1:0] IF_PCOut,
    output logic [DATA_W-1:0] IF_PCAdd4,
    output logic              IF_IsBDS,
    output logic              IF_Stall,
    output logic              IF_Flush,
    output logic              IF_ExceptionFlush
);
    fetch_state_e      state;
    logic [DATA_W-1:0] pc, drain_addr, br_tgt;
    logic              bds_q, cancel_q, br_q, buf_cancel;
    logic              bds_n, cancel_n, br_set, cap, redirect;

    always_comb begin
        bds_n    = bds_q | (ID_IsBranch & ~ID_Stall);
        cancel_n = cancel_q | ID_CancelBDS;
        br_set   = ID_BranchTaken & ~ID_Stall;
        cap      = (state == REQ) & IMEM_Ack & ~EXC_Redirect;
        redirect = br_q & IF_IsBDS;
    end

    // DRAIN finishes the abandoned request at its original address
    assign IMEM_Req          = state != VALID;
    assign IMEM_Addr         = state == DRAIN ? drain_addr : pc;
    assign IF_Stall          = state != VALID;
    assign IF_Flush          = buf_cancel & ~IF_Stall;
    assign IF_ExceptionFlush = EXC_Redirect;

    if_fetch_buffer #(.DATA_W(DATA_W)) u_buf (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (cap),
        .clr      (EXC_Redirect),
        .d_instr  (IMEM_RData),
        .d_pc     (pc),
        .d_bds    (bds_n),
        .d_cancel (cancel_n),
        .instr    (IF_Instruction),
        .pc       (IF_PCOut),
        .pc_add4  (IF_PCAdd4),
        .is_bds   (IF_IsBDS),
        .cancel   (buf_cancel)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= REQ;
            pc         <= RESET_VECTOR;
            drain_addr <= '0;
            br_tgt     <= '0;
            bds_q      <= 1'b0;
            cancel_q   <= 1'b0;
            br_q       <= 1'b0;
        end else if (EXC_Redirect) begin
            pc       <= word_align(EXC_Vector);
            bds_q    <= 1'b0;
            cancel_q <= 1'b0;
            br_q     <= 1'b0;
            state    <= (state != VALID && !IMEM_Ack) ? DRAIN : REQ;
            if (state == REQ)
                drain_addr <= pc;
        end else begin
            bds_q    <= cap ? 1'b0 : bds_n;
            cancel_q <= cap ? 1'b0 : cancel_n;
            case (state)
                REQ:     if (IMEM_Ack) state <= VALID;
                VALID:   if (!ID_Stall) begin
                             state <= REQ;
                             pc    <= redirect ? br_tgt : pc + DATA_W'(4);
                             if (redirect)
                                 br_q <= 1'b0;
                         end
                default: if (IMEM_Ack) state <= REQ;
            endcase
            if (br_set) begin
                br_q   <= 1'b1;
                br_tgt <= word_align(ID_BranchTarget);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plan plus randomized traffic against a fetch-level reference model
module tb_if_fetch_unit;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        IMEM_Req, IMEM_Ack = 1'b0;
    logic [31:0] IMEM_Addr, IMEM_RData = '0;
    logic        ID_Stall = 1'b0, ID_IsBranch = 1'b0, ID_BranchTaken = 1'b0, ID_CancelBDS = 1'b0;
    logic [31:0] ID_BranchTarget = '0, EXC_Vector = '0;
    logic        EXC_Redirect = 1'b0;
    logic [31:0] IF_Instruction, IF_PCOut, IF_PCAdd4;
    logic        IF_IsBDS, IF_Stall, IF_Flush, IF_ExceptionFlush;

    int checks = 0, errors = 0;

    // reference: "have" = one instruction held for ID, "discard" = an abandoned fetch still owed an ack
    bit          m_have, m_discard, m_bds, m_cancel, m_br, m_bbds, m_bcancel;
    logic [31:0] m_pc, m_stale, m_tgt, m_instr, m_bpc;

    always #5 CLK = ~CLK;

    if_fetch_unit dut (
        .CLK(CLK), .RST_N(RST_N),
        .IMEM_Req(IMEM_Req), .IMEM_Addr(IMEM_Addr), .IMEM_Ack(IMEM_Ack), .IMEM_RData(IMEM_RData),
        .ID_Stall(ID_Stall), .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
        .ID_BranchTarget(ID_BranchTarget), .ID_CancelBDS(ID_CancelBDS),
        .EXC_Redirect(EXC_Redirect), .EXC_Vector(EXC_Vector),
        .IF_Instruction(IF_Instruction), .IF_PCOut(IF_PCOut), .IF_PCAdd4(IF_PCAdd4),
        .IF_IsBDS(IF_IsBDS), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush),
        .IF_ExceptionFlush(IF_ExceptionFlush)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0137_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_discard = 0; m_bds = 0; m_cancel = 0; m_br = 0;
        m_bbds = 0; m_bcancel = 0; m_pc = 32'hBFC0_0000; m_stale = '0; m_tgt = '0;
        m_instr = '0; m_bpc = '0;
    endtask

    task automatic compare();
        chk("req", 32'(IMEM_Req), 32'(!m_have));
        if (!m_have) chk("addr", IMEM_Addr, m_discard ? m_stale : m_pc);
        chk("stall", 32'(IF_Stall), 32'(!m_have));
        chk("excflush", 32'(IF_ExceptionFlush), 32'(EXC_Redirect));
        chk("flush", 32'(IF_Flush), 32'(m_have & m_bcancel));
        if (m_have) begin
            chk("instr", IF_Instruction, m_instr);
            chk("pcout", IF_PCOut, m_bpc);
            chk("pcadd4", IF_PCAdd4, m_bpc + 32'd4);
            chk("isbds", 32'(IF_IsBDS), 32'(m_bbds));
        end
    endtask

    task automatic model_update();
        bit nb, nc;
        if (EXC_Redirect) begin
            if (!m_have && !m_discard && !IMEM_Ack) begin
                m_discard = 1;
                m_stale   = m_pc;
            end else if (m_discard && IMEM_Ack) m_discard = 0;
            m_have = 0; m_pc = {EXC_Vector[31:2], 2'b00};
            m_bds = 0; m_cancel = 0; m_br = 0; m_bcancel = 0;
        end else begin
            nb = m_bds | (ID_IsBranch & !ID_Stall);
            nc = m_cancel | ID_CancelBDS;
            if (!m_have && IMEM_Ack) begin
                if (m_discard) m_discard = 0;
                else begin
                    m_have = 1; m_instr = mem(m_pc); m_bpc = m_pc;
                    m_bbds = nb; m_bcancel = nc; nb = 0; nc = 0;
                end
            end else if (m_have && !ID_Stall) begin
                m_have = 0;
                if (m_br && m_bbds) begin
                    m_pc = m_tgt;
                    m_br = 0;
                end else m_pc = m_pc + 32'd4;
            end
            m_bds = nb; m_cancel = nc;
            if (ID_BranchTaken && !ID_Stall) begin
                m_br  = 1;
                m_tgt = {ID_BranchTarget[31:2], 2'b00};
            end
        end
    endtask

    // called at posedge+1 with inputs already set; leaves time at the next posedge+1
    task automatic step();
        IMEM_RData = m_discard ? 32'hDEAD_BEEF : mem(m_pc);
        @(negedge CLK);
        compare();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IMEM_Ack = 0; ID_Stall = 0; ID_IsBranch = 0; ID_BranchTaken = 0;
        ID_CancelBDS = 0; EXC_Redirect = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_addr", IMEM_Addr, 32'hBFC0_0000);
        chk("rst_req", 32'(IMEM_Req), 32'd1);
        chk("rst_stall", 32'(IF_Stall), 32'd1);
        chk("rst_instr", IF_Instruction, 32'd0);
        chk("rst_pcadd4", IF_PCAdd4, 32'd0);
        RST_N = 1;

        IMEM_Ack = 1; step();
        chk("t1_pcadd4", IF_PCAdd4, 32'hBFC0_0004);
        chk("t1_stall", 32'(IF_Stall), 32'd0);
        step();
        chk("t1_addr2", IMEM_Addr, 32'hBFC0_0004);
        step(); step();
        chk("t1_addr3", IMEM_Addr, 32'hBFC0_0008);

        IMEM_Ack = 0; ID_IsBranch = 1; ID_BranchTaken = 1; ID_BranchTarget = 32'h0040_0100; step();
        ID_IsBranch = 0; ID_BranchTaken = 0; IMEM_Ack = 1; step();
        chk("t3_bds", 32'(IF_IsBDS), 32'd1);
        chk("t3_bdspc", IF_PCOut, 32'hBFC0_0008);
        IMEM_Ack = 0; step();
        chk("t3_tgt", IMEM_Addr, 32'h0040_0100);
        IMEM_Ack = 1; step();
        chk("t3_nobds", 32'(IF_IsBDS), 32'd0);
        IMEM_Ack = 0; step();

        ID_IsBranch = 1; ID_CancelBDS = 1; step();
        idle_inputs(); IMEM_Ack = 1; step();
        chk("t4_flush", 32'(IF_Flush), 32'd1);
        chk("t4_bds", 32'(IF_IsBDS), 32'd1);
        IMEM_Ack = 0; step();
        chk("t4_fall", IMEM_Addr, 32'h0040_0108);

        repeat (3) step();
        chk("t2_hold", IMEM_Addr, 32'h0040_0108);
        IMEM_Ack = 1; step();
        IMEM_Ack = 0; ID_Stall = 1;
        repeat (4) step();
        chk("t2_noreq", 32'(IMEM_Req), 32'd0);
        chk("t2_frozen", IF_PCOut, 32'h0040_0108);
        ID_Stall = 0; step();

        EXC_Redirect = 1; EXC_Vector = 32'h8000_0180; step();
        EXC_Redirect = 0; IMEM_Ack = 1;
        chk("t5_drain", IMEM_Addr, 32'h0040_010C);
        step();
        chk("t5_vec", IMEM_Addr, 32'h8000_0180);
        step();
        chk("t5_instr", IF_Instruction, mem(32'h8000_0180));
        chk("t5_bds", 32'(IF_IsBDS), 32'd0);

        EXC_Redirect = 1; EXC_Vector = 32'hFFFF_FFFF; IMEM_Ack = 0; ID_Stall = 1; step();
        EXC_Redirect = 0; ID_Stall = 0; IMEM_Ack = 1; step();
        chk("t6_pc", IF_PCOut, 32'hFFFF_FFFC);
        chk("t6_wrap", IF_PCAdd4, 32'h0000_0000);
        IMEM_Ack = 0; step();
        chk("t6_addr", IMEM_Addr, 32'h0000_0000);

        for (int i = 0; i < 3000; i++) begin
            IMEM_Ack        = $urandom_range(0, 1) == 1;
            ID_Stall        = $urandom_range(0, 3) == 0;
            ID_IsBranch     = $urandom_range(0, 7) == 0;
            ID_BranchTaken  = $urandom_range(0, 9) == 0;
            ID_BranchTarget = $urandom;
            ID_CancelBDS    = $urandom_range(0, 15) == 0;
            EXC_Redirect    = $urandom_range(0, 19) == 0;
            EXC_Vector      = $urandom;
            step();
        end

        idle_inputs();
        repeat (2) step();
        #2 RST_N = 0;
        #1;
        chk("arst_stall", 32'(IF_Stall), 32'd1);
        chk("arst_addr", IMEM_Addr, 32'hBFC0_0000);
        chk("arst_instr", IF_Instruction, 32'd0);
        chk("arst_pcout", IF_PCOut, 32'd0);
        chk("arst_flags", {29'd0, IF_IsBDS, IF_Flush, IMEM_Req}, 32'd1);
        model_reset();
        @(posedge CLK);
        #1 RST_N = 1;
        IMEM_Ack = 1; step();
        chk("post_rst", IF_PCOut, 32'hBFC0_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
